// File: rtl/parking_occupancy_tracker.sv
// Parking occupancy tracker: counts cars in via the entry FSM and out via a debounced exit sensor.
// Latency: count, events and error flags update on the edge that completes a passage; decodes are combinational.
// Backpressure: none; inputs are sampled every cycle. Optional almost_full output when PARK_ALMOST_FULL_EN is defined.
module parking_occupancy_tracker #(
   parameter int CAPACITY      = 8,
   parameter int COUNT_W       = 4,
   parameter int EXIT_DEBOUNCE = 3
`ifdef PARK_ALMOST_FULL_EN
   ,
   parameter int ALMOST_FULL_TH = 2
`endif
) (
   input  logic               i_clock,
   input  logic               i_reset_n,
   input  logic               i_front_sensor,
   input  logic               i_back_sensor,
   input  logic               i_green_LED,
   input  logic               i_exit_sensor,
   input  logic               i_err_clear,
   output logic [COUNT_W-1:0] o_count,
   output logic [COUNT_W-1:0] o_free_slots,
   output logic               o_full,
   output logic               o_empty,
   output logic               o_entry_event,
   output logic               o_exit_event,
   output logic               o_overflow_err,
`ifdef PARK_ALMOST_FULL_EN
   output logic               o_almost_full,
`endif
   output logic               o_underflow_err
);

   // Debounce counter must hold the value EXIT_DEBOUNCE itself, where it saturates.
   localparam int                 DEB_W    = (EXIT_DEBOUNCE < 1) ? 1 : $clog2(EXIT_DEBOUNCE + 1);
   localparam logic [DEB_W-1:0]   DEB_MAX  = DEB_W'(EXIT_DEBOUNCE);
   localparam logic [DEB_W-1:0]   DEB_LAST = DEB_W'(EXIT_DEBOUNCE - 1);
   localparam logic [COUNT_W-1:0] CAP      = COUNT_W'(CAPACITY);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ARMED   = 2'd1,
      S_PASSING = 2'd2,
      S_DONE    = 2'd3
   } entry_state_t;

   entry_state_t       r_state;
   logic               r_entry_event;
   logic               r_exit_event;
   logic [DEB_W-1:0]   r_deb_cnt;
   logic               r_exit_armed;
   logic [COUNT_W-1:0] r_count;
   logic               r_overflow_err;
   logic               r_underflow_err;

   logic               w_entry_done;
   logic               w_exit_hit;
   logic               w_full;
   logic               w_empty;
   logic [COUNT_W-1:0] w_free;
   logic               w_inc;
   logic               w_dec;
   logic               w_ovf_set;
   logic               w_udf_set;
   logic [COUNT_W-1:0] w_count_nxt;

   // Entry completes on the edge that leaves PASSING; the DONE cycle then carries the pulse.
   assign w_entry_done = (r_state == S_PASSING) && !i_back_sensor;

   // Exit registers on the sample that takes the counter from EXIT_DEBOUNCE-1 to EXIT_DEBOUNCE.
   assign w_exit_hit = i_exit_sensor && r_exit_armed && (r_deb_cnt == DEB_LAST);

   // Occupancy decodes are taken straight from the count register.
   assign w_full  = (r_count == CAP);
   assign w_empty = (r_count == '0);
   assign w_free  = CAP - r_count;

   // Simultaneous entry and exit cancel: no count change and no error, even at the bounds.
   always_comb begin
      w_inc       = w_entry_done && !w_exit_hit;
      w_dec       = w_exit_hit && !w_entry_done;
      w_ovf_set   = w_inc && w_full;
      w_udf_set   = w_dec && w_empty;
      w_count_nxt = r_count;
      if (w_inc && !w_full) begin
         w_count_nxt = r_count + COUNT_W'(1);
      end else if (w_dec && !w_empty) begin
         w_count_nxt = r_count - COUNT_W'(1);
      end
   end

   // Entry FSM with its registered one-cycle event; a tailgater must re-arm from IDLE.
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state       <= S_IDLE;
         r_entry_event <= 1'b0;
      end else begin
         r_entry_event <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_green_LED && i_front_sensor) begin
                  r_state <= S_ARMED;
               end
            end
            S_ARMED: begin
               if (!i_green_LED) begin
                  r_state <= S_IDLE;
               end else if (i_back_sensor) begin
                  r_state <= S_PASSING;
               end
            end
            S_PASSING: begin
               if (!i_back_sensor) begin
                  r_state       <= S_DONE;
                  r_entry_event <= 1'b1;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Exit debounce: saturating run-length of high samples plus a latch that re-arms on a low sample.
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_deb_cnt    <= '0;
         r_exit_armed <= 1'b0;
         r_exit_event <= 1'b0;
      end else begin
         r_exit_event <= w_exit_hit;
         if (!i_exit_sensor) begin
            r_deb_cnt    <= '0;
            r_exit_armed <= 1'b1;
         end else begin
            if (r_deb_cnt != DEB_MAX) begin
               r_deb_cnt <= r_deb_cnt + DEB_W'(1);
            end
            if (w_exit_hit) begin
               r_exit_armed <= 1'b0;
            end
         end
      end
   end

   // Occupancy count and sticky error flags; a new error in the clearing cycle wins over the clear.
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_count         <= '0;
         r_overflow_err  <= 1'b0;
         r_underflow_err <= 1'b0;
      end else begin
         r_count         <= w_count_nxt;
         r_overflow_err  <= w_ovf_set || (r_overflow_err && !i_err_clear);
         r_underflow_err <= w_udf_set || (r_underflow_err && !i_err_clear);
      end
   end

   assign o_count         = r_count;
   assign o_free_slots    = w_free;
   assign o_full          = w_full;
   assign o_empty         = w_empty;
   assign o_entry_event   = r_entry_event;
   assign o_exit_event    = r_exit_event;
   assign o_overflow_err  = r_overflow_err;
   assign o_underflow_err = r_underflow_err;

`ifdef PARK_ALMOST_FULL_EN
   // Near-capacity warning; drops once the lot is actually full.
   assign o_almost_full = (w_free <= COUNT_W'(ALMOST_FULL_TH)) && !w_full;
`endif

endmodule

// File: tb/tb_parking_occupancy_tracker.sv
// Directed bench for parking_occupancy_tracker (CAPACITY=8, COUNT_W=4, EXIT_DEBOUNCE=3).
module tb_parking_occupancy_tracker;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       front, back, green, exit_s, err_clr;
   logic [3:0] count, free_slots;
   logic       full, empty, entry_ev, exit_ev, ovf, udf;
`ifdef PARK_ALMOST_FULL_EN
   logic       almost_full;
`endif

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   parking_occupancy_tracker #(
      .CAPACITY(8),
      .COUNT_W(4),
      .EXIT_DEBOUNCE(3)
   ) dut (
      .i_clock        (clk),
      .i_reset_n      (rst_n),
      .i_front_sensor (front),
      .i_back_sensor  (back),
      .i_green_LED    (green),
      .i_exit_sensor  (exit_s),
      .i_err_clear    (err_clr),
      .o_count        (count),
      .o_free_slots   (free_slots),
      .o_full         (full),
      .o_empty        (empty),
      .o_entry_event  (entry_ev),
      .o_exit_event   (exit_ev),
      .o_overflow_err (ovf),
`ifdef PARK_ALMOST_FULL_EN
      .o_almost_full  (almost_full),
`endif
      .o_underflow_err(udf)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle 1 ns past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Full entry pass; returns right after the edge that completes it (event visible).
   task automatic do_entry();
      green = 1'b1; front = 1'b1;
      tick();
      front = 1'b0; back = 1'b1;
      tick();
      back = 1'b0; green = 1'b0;
      tick();
   endtask

   // Entry followed by the DONE->IDLE cycle.
   task automatic entry_and_idle();
      do_entry();
      tick();
   endtask

   // Three-sample exit then a low sample to re-arm.
   task automatic exit_and_idle();
      exit_s = 1'b1;
      tick(); tick(); tick();
      exit_s = 1'b0;
      tick();
   endtask

   initial begin
      rst_n = 1'b0; front = 1'b0; back = 1'b0; green = 1'b0; exit_s = 1'b0; err_clr = 1'b0;
      #22;
      chk("rst_count", 32'(count), 0);
      chk("rst_free", 32'(free_slots), 8);
      chk("rst_full", 32'(full), 0);
      chk("rst_empty", 32'(empty), 1);
      chk("rst_entry_ev", 32'(entry_ev), 0);
      chk("rst_exit_ev", 32'(exit_ev), 0);
      chk("rst_ovf", 32'(ovf), 0);
      chk("rst_udf", 32'(udf), 0);
      rst_n = 1'b1;
      tick();

      // First entry
      do_entry();
      chk("e1_event", 32'(entry_ev), 1);
      chk("e1_count", 32'(count), 1);
      chk("e1_empty", 32'(empty), 0);
      chk("e1_free", 32'(free_slots), 7);
      tick();
      chk("e1_pulse_end", 32'(entry_ev), 0);
      chk("e1_count_hold", 32'(count), 1);

      // Aborted entry: green drops while ARMED
      green = 1'b1; front = 1'b1;
      tick();
      green = 1'b0; front = 1'b0;
      tick();
      green = 1'b1; back = 1'b1;
      tick();
      back = 1'b0;
      tick();
      chk("abort_no_event_a", 32'(entry_ev), 0);
      tick();
      chk("abort_no_event_b", 32'(entry_ev), 0);
      chk("abort_count", 32'(count), 1);
      green = 1'b0;
      tick();

      // Short exit burst (2 samples) registers nothing
      exit_s = 1'b1;
      tick();
      chk("burst2_s1", 32'(exit_ev), 0);
      tick();
      chk("burst2_s2", 32'(exit_ev), 0);
      exit_s = 1'b0;
      tick();
      chk("burst2_after", 32'(exit_ev), 0);
      chk("burst2_count", 32'(count), 1);

      // Long burst (5 samples): exactly one event on the 3rd sample
      exit_s = 1'b1;
      tick();
      chk("burst5_s1", 32'(exit_ev), 0);
      tick();
      chk("burst5_s2", 32'(exit_ev), 0);
      tick();
      chk("burst5_s3", 32'(exit_ev), 1);
      chk("burst5_count", 32'(count), 0);
      chk("burst5_empty", 32'(empty), 1);
      tick();
      chk("burst5_s4", 32'(exit_ev), 0);
      tick();
      chk("burst5_s5", 32'(exit_ev), 0);
      chk("burst5_udf", 32'(udf), 0);
      exit_s = 1'b0;
      tick();

      // Fill to capacity
      for (int i = 0; i < 8; i++) entry_and_idle();
      chk("fill_count", 32'(count), 8);
      chk("fill_full", 32'(full), 1);
      chk("fill_free", 32'(free_slots), 0);
      chk("fill_ovf", 32'(ovf), 0);

      // Ninth entry overflows
      do_entry();
      chk("e9_event", 32'(entry_ev), 1);
      chk("e9_count", 32'(count), 8);
      chk("e9_ovf", 32'(ovf), 1);
      tick();
      tick();
      chk("ovf_sticky", 32'(ovf), 1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("ovf_cleared", 32'(ovf), 0);

      // Simultaneous entry and exit at full
      exit_s = 1'b1; green = 1'b1; front = 1'b1;
      tick();
      front = 1'b0; back = 1'b1;
      tick();
      back = 1'b0; green = 1'b0;
      tick();
      chk("sim_full_entry_ev", 32'(entry_ev), 1);
      chk("sim_full_exit_ev", 32'(exit_ev), 1);
      chk("sim_full_count", 32'(count), 8);
      chk("sim_full_ovf", 32'(ovf), 0);
      chk("sim_full_udf", 32'(udf), 0);
      exit_s = 1'b0;
      tick();

      // Overflow coinciding with err_clear: set wins
      green = 1'b1; front = 1'b1;
      tick();
      front = 1'b0; back = 1'b1;
      tick();
      back = 1'b0; green = 1'b0; err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("set_wins_ovf", 32'(ovf), 1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("set_wins_cleared", 32'(ovf), 0);

`ifdef PARK_ALMOST_FULL_EN
      chk("af_at8", 32'(almost_full), 0);
      exit_and_idle();
      exit_and_idle();
      chk("af_at6", 32'(almost_full), 1);
      exit_and_idle();
      chk("af_at5", 32'(almost_full), 0);
      exit_and_idle();
      exit_and_idle();
`else
      for (int i = 0; i < 5; i++) exit_and_idle();
`endif
      chk("drain_count", 32'(count), 3);
      chk("drain_free", 32'(free_slots), 5);

      // Reset while PASSING with count=3
      green = 1'b1; front = 1'b1;
      tick();
      front = 1'b0; back = 1'b1;
      tick();
      rst_n = 1'b0;
      #2;
      chk("midrst_count", 32'(count), 0);
      chk("midrst_empty", 32'(empty), 1);
      rst_n = 1'b1; back = 1'b0; green = 1'b0;
      tick();
      chk("midrst_no_event", 32'(entry_ev), 0);
      tick();
      chk("midrst_no_event2", 32'(entry_ev), 0);
      chk("midrst_count_after", 32'(count), 0);

      // Simultaneous entry and exit at empty
      exit_s = 1'b1; green = 1'b1; front = 1'b1;
      tick();
      front = 1'b0; back = 1'b1;
      tick();
      back = 1'b0; green = 1'b0;
      tick();
      chk("sim_empty_exit_ev", 32'(exit_ev), 1);
      chk("sim_empty_count", 32'(count), 0);
      chk("sim_empty_udf", 32'(udf), 0);
      exit_s = 1'b0;
      tick();

      // Lone exit at empty underflows
      exit_s = 1'b1;
      tick(); tick(); tick();
      chk("udf_exit_ev", 32'(exit_ev), 1);
      chk("udf_count", 32'(count), 0);
      chk("udf_flag", 32'(udf), 1);
      exit_s = 1'b0;
      tick();
      chk("udf_sticky", 32'(udf), 1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("udf_cleared", 32'(udf), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/parking_occupancy_tracker.md
Name: parking_occupancy_tracker

Overview:
- Downstream of the gate controller. Consumes its green_LED (gate open) output and the same front/back sensors, plus an exit-lane sensor.
- Tracks how many slots are occupied and publishes count, free slots, full and empty.
- The full output feeds back to the lot signage and the entry-lane logic.

Parameters:
- CAPACITY, 8, total slots; range 1 to 2^COUNT_W-1.
- COUNT_W, 4, width of the count and free_slots outputs.
- EXIT_DEBOUNCE, 3, consecutive high samples of exit_sensor needed to register one exit; minimum 1.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- front_sensor  in  1  entry-lane front sensor, same signal the gate controller sees.
- back_sensor  in  1  entry-lane back sensor.
- green_LED  in  1  gate-open indication from the gate controller.
- exit_sensor  in  1  exit-lane sensor, raw level.
- err_clear  in  1  synchronous clear of the sticky error flags.
- count  out  COUNT_W  occupied slots.
- free_slots  out  COUNT_W  equals CAPACITY - count.
- full  out  1  high when count == CAPACITY.
- empty  out  1  high when count == 0.
- entry_event  out  1  one-cycle pulse per completed entry.
- exit_event  out  1  one-cycle pulse per registered exit.
- overflow_err  out  1  sticky: an entry completed while full.
- underflow_err  out  1  sticky: an exit registered while empty.

Behaviour:
- Reset, asynchronous, active-low:
  - count=0, free_slots=CAPACITY, full=0, empty=1.
  - entry_event=0, exit_event=0, overflow_err=0, underflow_err=0.
  - Entry FSM returns to IDLE; debounce counter and exit re-arm latch are cleared.
  - Reset asserted mid-passage discards the partial entry; no event is produced.
- Entry FSM (registered state; inputs sampled each rising edge):
  - IDLE -> ARMED when green_LED=1 and front_sensor=1.
  - ARMED -> PASSING when back_sensor=1 and green_LED=1.
  - ARMED -> IDLE when green_LED=0 (aborted entry, no event).
  - PASSING -> DONE when back_sensor=0.
  - PASSING holds while back_sensor=1, regardless of green_LED.
  - DONE -> IDLE unconditionally. entry_event=1 only for the single cycle state==DONE.
  - Exactly one entry_event per car. A tailgating car triggers no second event until the FSM is back in IDLE and re-armed.
- Exit debounce:
  - A saturating counter increments while exit_sensor=1 and clears when exit_sensor=0.
  - On the edge where the counter reaches EXIT_DEBOUNCE, exit_event is registered high for one cycle.
  - No further exit_event until exit_sensor has been sampled 0 at least once (re-arm).
- Counter update, on the same edge that raises the event pulse; count is visible with the pulse:
  - entry only, count<CAPACITY: count+1.
  - entry only, full: count unchanged, overflow_err set.
  - exit only, count>0: count-1.
  - exit only, empty: count unchanged, underflow_err set.
  - entry and exit in the same cycle: count unchanged, no error flag, even at full or empty.
- free_slots, full and empty are combinational decodes of the count register; zero added latency.
- err_clear=1 clears both sticky flags on the next edge. If a new error occurs in that same cycle, set wins over clear.
- count never wraps; it is bounded to 0..CAPACITY.

Optional Feature:
- Macro: PARK_ALMOST_FULL_EN.
- When defined:
  - Adds parameter ALMOST_FULL_TH (default 2).
  - Adds output almost_full (1 bit), high when free_slots <= ALMOST_FULL_TH and full=0. It is a combinational decode of count and 0 on reset.
- When undefined: neither the parameter nor the port exists; all other behaviour is identical.

Test Plan:
- Reset release, then a full entry pass (green_LED=1, front_sensor=1; then back_sensor=1; then back_sensor=0) -> one-cycle entry_event, count 0->1, empty 1->0, free_slots=7.
- ARMED with green_LED dropped before back_sensor rises -> no entry_event, count unchanged, FSM in IDLE.
- exit_sensor high 2 cycles then low; later high 5 cycles (EXIT_DEBOUNCE=3) -> first burst gives no event; second gives exactly one exit_event, on the 3rd high sample.
- 8 entries then a 9th entry -> full=1 after the 8th; after the 9th, count stays 8 and overflow_err=1; pulsing err_clear then returns overflow_err to 0.
- count=8, entry_event and exit_event in the same cycle -> count stays 8, no error. Then at count=0, a lone exit -> count 0, underflow_err=1.
- Reset asserted while the entry FSM is in PASSING with count=3 -> immediately count=0, no entry_event. With PARK_ALMOST_FULL_EN, count=6 gives almost_full=1 and count=8 gives almost_full=0.
